// File: rtl/trdb_pkg.sv
// rtl/trdb_pkg.sv - shared packet/state types and request helpers for the trace sequencer
package trdb_pkg;

  // Packet formats understood by the emitter.
  typedef enum logic [1:0] {
    F_OPT_EXT    = 2'b00,
    F_DIFF_DELTA = 2'b01,
    F_ADDR_ONLY  = 2'b10,
    F_SYNC       = 2'b11
  } trdb_format_e;

  // Subformats of F_SYNC.
  typedef enum logic [1:0] {
    SF_START   = 2'b00,
    SF_TRAP    = 2'b01,
    SF_CONTEXT = 2'b10,
    SF_SUPPORT = 2'b11
  } trdb_f_sync_subformat_e;

  // Qualification status carried in SF_SUPPORT packets.
  typedef enum logic [1:0] {
    QS_NO_CHANGE  = 2'b00,
    QS_ENDED_REP  = 2'b01,
    QS_TRACE_LOST = 2'b10,
    QS_ENDED_NTR  = 2'b11
  } trdb_qual_status_e;

  // Trace on/off sequencing states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SUP_ON  = 3'd1,
    SYNC    = 3'd2,
    RUN     = 3'd3,
    SUP_OFF = 3'd4
  } trdb_seq_state_e;

  // Contents of the one-entry request register (valid bit kept separately).
  typedef struct packed {
    trdb_format_e           fmt;
    trdb_f_sync_subformat_e sub;
    trdb_qual_status_e      qual;
    logic                   timeout;
  } trdb_req_t;

  // Branch-map fill count at which the map must be drained.
  localparam logic [4:0] BRANCH_MAP_FULL = 5'd31;

  function automatic trdb_req_t mk_req(
    input trdb_format_e           fmt,
    input trdb_f_sync_subformat_e sub,
    input trdb_qual_status_e      qual,
    input logic                   timeout
  );
    trdb_req_t r;
    r.fmt     = fmt;
    r.sub     = sub;
    r.qual    = qual;
    r.timeout = timeout;
    return r;
  endfunction

  // SF_START and SF_TRAP restart the decoder's view, so they also restart the resync timer.
  function automatic logic req_restarts(input trdb_req_t r);
    return (r.fmt == F_SYNC) && ((r.sub == SF_START) || (r.sub == SF_TRAP));
  endfunction

  // Packets that consume the branch map and therefore empty it once accepted.
  function automatic logic req_flushes(input trdb_req_t r);
    return req_restarts(r) || (r.fmt == F_DIFF_DELTA);
  endfunction

endpackage

// File: rtl/trdb_resync_counter.sv
// rtl/trdb_resync_counter.sv - saturating retirement counter raising a periodic resync flag
module trdb_resync_counter
  import trdb_pkg::*;
#(
  parameter int unsigned RESYNC_MAX = 1024,
  parameter int unsigned CNT_W      = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic pending_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESYNC_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             pending_q, pending_d;

  // Count qualified retirements, hold at the last value and latch the resync request there
  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    cnt_inc   = (cnt_q == CNT_LAST) ? cnt_q : (cnt_q + CNT_ONE);
    if (clr_i) begin
      cnt_d     = '0;
      pending_d = 1'b0;
    end else if (en_i) begin
      cnt_d = cnt_inc;
      if (cnt_inc == CNT_LAST) begin
        pending_d = 1'b1;
      end
    end
  end

  // Counter and flag registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/trdb_packet_sequencer.sv
// rtl/trdb_packet_sequencer.sv - decides which trace packet to request from the emitter, and when
module trdb_packet_sequencer
  import trdb_pkg::*;
#(
  parameter int unsigned RESYNC_MAX = 1024,
  parameter int unsigned CNT_W      = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       valid_i,
  input  logic       exception_i,
  input  logic       priv_change_i,
  input  logic       updiscon_i,
  input  logic [4:0] branches_i,
  input  logic       req_ready_i,
  output logic       req_valid_o,
  output logic [1:0] packet_format_o,
  output logic [1:0] packet_f_sync_subformat_o,
  output logic [1:0] qual_status_o,
  output logic       resync_timeout_o,
  output logic       branch_map_flush_o,
  output logic       stall_o
);

  trdb_seq_state_e state_q, state_d;
  trdb_req_t       req_q, req_d;
  logic            req_valid_q, req_valid_d;
  logic            flush_q, flush_d;

  logic            accept;
  logic            slot_free;
  logic            stall;
  logic            shutdown;
  logic            sync_accept;
  logic            resync_pending;
  logic            resync_due;
  logic            cnt_en;
  logic            cnt_clr;
  logic            run_hit;
  trdb_req_t       run_req;

  // A new request may load in the same cycle the current one is accepted.
  assign accept      = req_valid_q & req_ready_i;
  assign slot_free   = ~req_valid_q | req_ready_i;
  assign stall       = req_valid_q & ~req_ready_i;
  assign shutdown    = slot_free & ~enable_i;
  assign sync_accept = accept & req_restarts(req_q);
  // A restart being accepted this cycle already satisfies the timer.
  assign resync_due  = resync_pending & ~sync_accept;
  assign cnt_en      = (state_q == RUN) & valid_i & ~stall;
  assign cnt_clr     = (state_q != RUN) | sync_accept;

  trdb_resync_counter #(
    .RESYNC_MAX (RESYNC_MAX),
    .CNT_W      (CNT_W)
  ) u_resync_counter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (cnt_en),
    .clr_i     (cnt_clr),
    .pending_o (resync_pending)
  );

  // Priority decode of the packet a retirement asks for while tracing runs
  always_comb begin
    run_hit = 1'b1;
    run_req = '0;
    if (exception_i) begin
      run_req = mk_req(F_SYNC, SF_TRAP, QS_NO_CHANGE, 1'b0);
    end else if (priv_change_i | resync_due) begin
      run_req = mk_req(F_SYNC, SF_START, QS_NO_CHANGE, ~priv_change_i);
    end else if (updiscon_i) begin
      run_req.fmt = (branches_i == 5'd0) ? F_ADDR_ONLY : F_DIFF_DELTA;
    end else if (branches_i == BRANCH_MAP_FULL) begin
      run_req.fmt = F_DIFF_DELTA;
    end else begin
      run_hit = 1'b0;
    end
  end

  // Next state of the sequencer and of the one-entry request register
  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_d       = req_q;
    flush_d     = accept & req_flushes(req_q);
    if (accept) begin
      req_valid_d = 1'b0;
      req_d       = '0;
    end
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          req_valid_d = 1'b1;
          req_d       = mk_req(F_SYNC, SF_SUPPORT, QS_NO_CHANGE, 1'b0);
          state_d     = SUP_ON;
        end
      end
      SUP_ON: begin
        if (shutdown) begin
          req_valid_d = 1'b1;
          req_d       = mk_req(F_SYNC, SF_SUPPORT, QS_ENDED_REP, 1'b0);
          state_d     = SUP_OFF;
        end else if (accept) begin
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (shutdown) begin
          req_valid_d = 1'b1;
          req_d       = mk_req(F_SYNC, SF_SUPPORT, QS_ENDED_REP, 1'b0);
          state_d     = SUP_OFF;
        end else if (req_valid_q) begin
          if (accept) begin
            state_d = RUN;
            // Tracing is live from this cycle, so a retirement here is decoded normally.
            if (valid_i && run_hit) begin
              req_valid_d = 1'b1;
              req_d       = run_req;
            end
          end
        end else if (valid_i) begin
          req_valid_d = 1'b1;
          req_d       = mk_req(F_SYNC, SF_START, QS_NO_CHANGE, 1'b0);
        end
      end
      RUN: begin
        if (shutdown) begin
          // Disable wins over any same-cycle event, which is dropped.
          req_valid_d = 1'b1;
          req_d       = mk_req(F_SYNC, SF_SUPPORT, QS_ENDED_REP, 1'b0);
          state_d     = SUP_OFF;
        end else if (slot_free && valid_i && run_hit) begin
          req_valid_d = 1'b1;
          req_d       = run_req;
        end
      end
      SUP_OFF: begin
        if (accept) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        req_valid_d = 1'b0;
        req_d       = '0;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_q       <= '0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_q       <= req_d;
      flush_q     <= flush_d;
    end
  end

  assign req_valid_o               = req_valid_q;
  assign packet_format_o           = req_q.fmt;
  assign packet_f_sync_subformat_o = req_q.sub;
  assign qual_status_o             = req_q.qual;
  assign resync_timeout_o          = req_q.timeout;
  assign branch_map_flush_o        = flush_q;
  assign stall_o                   = stall;

endmodule

// File: tb/tb_trdb_packet_sequencer.sv
// tb/tb_trdb_packet_sequencer.sv - self-checking bench for trdb_packet_sequencer
module tb_trdb_packet_sequencer;

  localparam int RMAX = 8;

  logic       clk;
  logic       rst;
  logic       enable_i, valid_i, exception_i, priv_change_i, updiscon_i, req_ready_i;
  logic [4:0] branches_i;
  logic       req_valid_o, resync_timeout_o, branch_map_flush_o, stall_o;
  logic [1:0] packet_format_o, packet_f_sync_subformat_o, qual_status_o;

  int checks = 0;
  int errors = 0;

  trdb_packet_sequencer #(.RESYNC_MAX(RMAX), .CNT_W(16)) dut (
    .clk_i                     (clk),
    .rst_i                     (rst),
    .enable_i                  (enable_i),
    .valid_i                   (valid_i),
    .exception_i               (exception_i),
    .priv_change_i             (priv_change_i),
    .updiscon_i                (updiscon_i),
    .branches_i                (branches_i),
    .req_ready_i               (req_ready_i),
    .req_valid_o               (req_valid_o),
    .packet_format_o           (packet_format_o),
    .packet_f_sync_subformat_o (packet_f_sync_subformat_o),
    .qual_status_o             (qual_status_o),
    .resync_timeout_o          (resync_timeout_o),
    .branch_map_flush_o        (branch_map_flush_o),
    .stall_o                   (stall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model. phase: 0 off, 1 announcing start, 2 awaiting first retirement,
  // 3 tracing, 4 announcing end. Formats/subformats as plain numbers.
  int m_phase = 0, m_fmt = 0, m_sub = 0, m_qual = 0, m_ret = 0;
  bit m_valid = 0, m_to = 0, m_flush = 0;
  int n_phase, n_fmt, n_sub, n_qual, n_ret, d_fmt, d_sub;
  bit n_valid, n_to, n_flush, d_hit, d_to, acc, free, restart, ev, due;

  always_comb begin
    n_phase = m_phase; n_valid = m_valid; n_fmt = m_fmt; n_sub = m_sub;
    n_qual = m_qual; n_to = m_to; n_ret = m_ret;
    acc     = m_valid && req_ready_i;
    free    = !m_valid || req_ready_i;
    restart = acc && (m_fmt == 3) && (m_sub <= 1);
    n_flush = acc && ((m_fmt == 1) || restart);
    ev      = valid_i && free;
    due     = (m_ret >= RMAX - 1) && !restart;
    if (acc) begin
      n_valid = 0; n_fmt = 0; n_sub = 0; n_qual = 0; n_to = 0;
    end
    if (m_phase == 3 && ev) n_ret = m_ret + 1;
    if (m_phase != 3 || restart) n_ret = 0;
    // lowest priority first, higher rules overwrite
    d_hit = 0; d_fmt = 0; d_sub = 0; d_to = 0;
    if (branches_i == 5'd31) begin d_hit = 1; d_fmt = 1; end
    if (updiscon_i) begin d_hit = 1; d_fmt = (branches_i == 5'd0) ? 2 : 1; end
    if (priv_change_i || due) begin d_hit = 1; d_fmt = 3; d_sub = 0; d_to = !priv_change_i; end
    if (exception_i) begin d_hit = 1; d_fmt = 3; d_sub = 1; d_to = 0; end
    if (m_phase == 0) begin
      if (enable_i) begin
        n_valid = 1; n_fmt = 3; n_sub = 3; n_qual = 0; n_to = 0; n_phase = 1;
      end
    end else if (m_phase == 4) begin
      if (acc) n_phase = 0;
    end else if (free && !enable_i) begin
      n_valid = 1; n_fmt = 3; n_sub = 3; n_qual = 1; n_to = 0; n_phase = 4;
    end else if (m_phase == 1) begin
      if (acc) n_phase = 2;
    end else if (m_phase == 2) begin
      if (m_valid) begin
        if (acc) begin
          n_phase = 3;
          if (valid_i && d_hit) begin
            n_valid = 1; n_fmt = d_fmt; n_sub = d_sub; n_qual = 0; n_to = d_to;
          end
        end
      end else if (valid_i) begin
        n_valid = 1; n_fmt = 3; n_sub = 0; n_qual = 0; n_to = 0;
      end
    end else if (ev && d_hit) begin
      n_valid = 1; n_fmt = d_fmt; n_sub = d_sub; n_qual = 0; n_to = d_to;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_valid <= 0; m_fmt <= 0; m_sub <= 0; m_qual <= 0;
      m_to <= 0; m_flush <= 0; m_ret <= 0;
    end else begin
      m_phase <= n_phase; m_valid <= n_valid; m_fmt <= n_fmt; m_sub <= n_sub;
      m_qual <= n_qual; m_to <= n_to; m_flush <= n_flush; m_ret <= n_ret;
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    cmp("m.req_valid", req_valid_o, m_valid);
    cmp("m.format", packet_format_o, m_fmt);
    cmp("m.subformat", packet_f_sync_subformat_o, m_sub);
    cmp("m.qual", qual_status_o, m_qual);
    cmp("m.timeout", resync_timeout_o, m_to);
    cmp("m.flush", branch_map_flush_o, m_flush);
    cmp("m.stall", stall_o, m_valid && !req_ready_i);
  end

  task automatic chk_now(input string nm, input int v, input int f, input int s,
                         input int q, input int to, input int fl, input int st);
    cmp({nm, ".valid"}, req_valid_o, v);
    cmp({nm, ".format"}, packet_format_o, f);
    cmp({nm, ".subformat"}, packet_f_sync_subformat_o, s);
    cmp({nm, ".qual"}, qual_status_o, q);
    cmp({nm, ".timeout"}, resync_timeout_o, to);
    cmp({nm, ".flush"}, branch_map_flush_o, fl);
    cmp({nm, ".stall"}, stall_o, st);
  endtask

  task automatic lit(input string nm, input int v, input int f, input int s,
                     input int q, input int to, input int fl, input int st);
    @(negedge clk);
    chk_now(nm, v, f, s, q, to, fl, st);
  endtask

  task automatic tk(input logic en, input logic v, input logic exc, input logic priv,
                    input logic upd, input logic [4:0] br, input logic rdy);
    @(posedge clk);
    #2;
    enable_i = en; valid_i = v; exception_i = exc; priv_change_i = priv;
    updiscon_i = upd; branches_i = br; req_ready_i = rdy;
  endtask

  task automatic idle();
    tk(1, 0, 0, 0, 0, 5'd0, 1);
  endtask

  initial begin
    rst = 1'b1;
    enable_i = 0; valid_i = 0; exception_i = 0; priv_change_i = 0;
    updiscon_i = 0; branches_i = 5'd0; req_ready_i = 0;
    @(negedge clk);
    chk_now("reset", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // start-up
    idle();
    idle();                      lit("sup_on", 1, 3, 3, 0, 0, 0, 0);
    tk(1, 1, 0, 0, 0, 5'd0, 1);
    idle();                      lit("start", 1, 3, 0, 0, 0, 0, 0);
    idle();                      lit("start_flush", 0, 0, 0, 0, 0, 1, 0);

    // backpressure on a trap
    tk(1, 1, 1, 0, 0, 5'd0, 0);
    tk(1, 0, 0, 0, 0, 5'd0, 0);  lit("trap_hold1", 1, 3, 1, 0, 0, 0, 1);
    tk(1, 0, 0, 0, 0, 5'd0, 0);  lit("trap_hold2", 1, 3, 1, 0, 0, 0, 1);
    tk(1, 0, 0, 0, 0, 5'd0, 0);  lit("trap_hold3", 1, 3, 1, 0, 0, 0, 1);
    idle();                      lit("trap_rel", 1, 3, 1, 0, 0, 0, 0);
    idle();                      lit("trap_flush", 0, 0, 0, 0, 0, 1, 0);

    // updiscon split and trap priority
    tk(1, 1, 0, 0, 1, 5'd0, 1);
    idle();                      lit("addr_only", 1, 2, 0, 0, 0, 0, 0);
    tk(1, 1, 0, 0, 1, 5'd5, 1);
    idle();                      lit("diff_delta", 1, 1, 0, 0, 0, 0, 0);
    idle();                      lit("dd_flush", 0, 0, 0, 0, 0, 1, 0);
    tk(1, 1, 1, 0, 1, 5'd3, 1);
    idle();                      lit("trap_over_upd", 1, 3, 1, 0, 0, 0, 0);
    idle();

    // full branch map
    tk(1, 1, 0, 0, 0, 5'd31, 1);
    idle();                      lit("full_map", 1, 1, 0, 0, 0, 0, 0);
    idle();                      lit("full_flush", 0, 0, 0, 0, 0, 1, 0);

    // privilege change, then resync timer twice
    tk(1, 1, 0, 1, 0, 5'd0, 1);
    idle();                      lit("priv_start", 1, 3, 0, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < RMAX; i++) tk(1, 1, 0, 0, 0, 5'd0, 1);
    idle();                      lit("timer_start", 1, 3, 0, 0, 1, 0, 0);
    idle();                      lit("timer_flush", 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < RMAX; i++) tk(1, 1, 0, 0, 0, 5'd0, 1);
    idle();                      lit("timer_again", 1, 3, 0, 0, 1, 0, 0);
    idle();

    // disable with a same-cycle event
    tk(0, 1, 1, 0, 0, 5'd0, 1);
    tk(0, 0, 0, 0, 0, 5'd0, 1);  lit("off_evt", 1, 3, 3, 1, 0, 0, 0);
    tk(0, 0, 0, 0, 0, 5'd0, 1);  lit("idle_again", 0, 0, 0, 0, 0, 0, 0);

    // re-enable, then disable while a request is pending
    idle();
    idle();                      lit("sup_on2", 1, 3, 3, 0, 0, 0, 0);
    tk(1, 1, 0, 0, 0, 5'd0, 1);
    idle();                      lit("start2", 1, 3, 0, 0, 0, 0, 0);
    idle();
    tk(1, 1, 0, 0, 1, 5'd0, 0);
    tk(0, 1, 1, 0, 0, 5'd0, 0);  lit("pend1", 1, 2, 0, 0, 0, 0, 1);
    tk(0, 0, 0, 0, 0, 5'd0, 0);  lit("pend2", 1, 2, 0, 0, 0, 0, 1);
    tk(0, 0, 0, 0, 0, 5'd0, 1);  lit("pend_rel", 1, 2, 0, 0, 0, 0, 0);
    tk(0, 0, 0, 0, 0, 5'd0, 1);  lit("off_after_pend", 1, 3, 3, 1, 0, 0, 0);
    tk(0, 0, 0, 0, 0, 5'd0, 1);  lit("idle3", 0, 0, 0, 0, 0, 0, 0);

    // reset in the middle of a pending request
    tk(1, 0, 0, 0, 0, 5'd0, 0);
    tk(1, 0, 0, 0, 0, 5'd0, 0);  lit("sup_on3", 1, 3, 3, 0, 0, 0, 1);
    #2 rst = 1'b1;
    #1 chk_now("async_rst", 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tk(0, 0, 0, 0, 0, 5'd0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
